// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder: select/scan controls in, one-hot bank and index out.
interface scan_decoder_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
);
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  load;
  logic                  dir;
  logic [DWELL_W-1:0]    dwell;
  logic [(2**SEL_W)-1:0] out;
  logic [SEL_W-1:0]      idx;
  logic                  wrap;

  modport master (
    output en, mode, sel, load, dir, dwell,
    input  out, idx, wrap
  );

  modport slave (
    input  en, mode, sel, load, dir, dwell,
    output out, idx, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and auto-scan (chaser) modes.
// The outputs derive only from registered state, so out/idx/wrap change only on clock edges.
module scan_decoder #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  scan_decoder_if.slave dec_io
);
  localparam int unsigned N = 2 ** SEL_W;

  typedef enum logic [1:0] {StOff, StDirect, StScan} state_e;

  state_e             st_q, st_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       onehot;

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!dec_io.en) begin
      st_d = StOff;
    end else if (!dec_io.mode) begin
      st_d  = StDirect;
      idx_d = dec_io.sel;
      cnt_d = '0;
    end else begin
      st_d = StScan;
      if (dec_io.load) begin
        idx_d = dec_io.sel;
        cnt_d = '0;
      end else if (st_q != StScan) begin
        // Entry keeps the index; the dwell restarts from zero.
        cnt_d = '0;
      end else if (cnt_q >= dec_io.dwell) begin
        cnt_d = '0;
        if (dec_io.dir) begin
          idx_d  = idx_q - SEL_W'(1);
          wrap_d = (idx_q == '0);
        end else begin
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == '1);
        end
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= StOff;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    onehot = '0;
    if (st_q != StOff) begin
      onehot[idx_q] = 1'b1;
    end
  end

  assign dec_io.out  = onehot;
  assign dec_io.idx  = idx_q;
  assign dec_io.wrap = wrap_q;
endmodule
